// File: rtl/mdr_pkg.sv
// Shared types and helpers for the MDR multiply/divide/square-root datapath.
// Latency: none (package; types, constants and a combinational helper only).
// Backpressure: not applicable.

`ifndef MDR_CNT_W
// Width of an iteration counter that must hold the value dw itself
`define MDR_CNT_W(dw) ($clog2((dw) + 1))
`endif

package mdr_pkg;

   // Widest operand the generic helpers below can handle
   localparam int MDR_MAX_DW = 64;

   typedef enum logic [1:0] {
      MULT    = 2'b00,
      DIV     = 2'b01,
      SQRT    = 2'b10,
      OP_RSVD = 2'b11
   } mdr_op_e;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      PROCESSING = 3'd2,
      FIX        = 3'd3,
      DONE       = 3'd4,
      ERROR      = 3'd5
   } core_state_e;

   // Magnitude of a dw-bit value held in the low bits of v. When sgn is set
   // the value is two's complement; the most negative value maps to its
   // unsigned magnitude 2^(dw-1), which still fits in dw bits.
   function automatic logic [MDR_MAX_DW-1:0] abs_dw(input logic [MDR_MAX_DW-1:0] v,
                                                    input int dw,
                                                    input logic sgn);
      logic [MDR_MAX_DW-1:0] mask;
      logic [MDR_MAX_DW-1:0] msb_sh;
      mask   = (dw >= MDR_MAX_DW) ? '1 : ((MDR_MAX_DW'(1) << dw) - MDR_MAX_DW'(1));
      msb_sh = v >> (dw - 1);
      if (sgn && msb_sh[0])
         abs_dw = (~v + MDR_MAX_DW'(1)) & mask;
      else
         abs_dw = v & mask;
   endfunction

endpackage

// File: rtl/mdr_sign_unit.sv
// Operand magnitude/sign extraction and conditional result negation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.

module mdr_sign_unit
   import mdr_pkg::*;
#(
   parameter int DW = 10
) (
   input  logic            sgn,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [DW-1:0]   a_mag,
   output logic [DW-1:0]   b_mag,
   output logic            a_neg,
   output logic            b_neg,
   input  logic [2*DW-1:0] fix_p,
   input  logic            fix_p_neg,
   input  logic [DW-1:0]   fix_r,
   input  logic            fix_r_neg,
   output logic [2*DW-1:0] fix_p_out,
   output logic [DW-1:0]   fix_r_out
);

   // Signs only count when the operation runs in two's complement
   assign a_neg = sgn & a[DW-1];
   assign b_neg = sgn & b[DW-1];

   assign a_mag = DW'(abs_dw(MDR_MAX_DW'(a), DW, sgn));
   assign b_mag = DW'(abs_dw(MDR_MAX_DW'(b), DW, sgn));

   // Wide path carries the full product, or the quotient in its low half
   assign fix_p_out = fix_p_neg ? (~fix_p + (2*DW)'(1)) : fix_p;
   assign fix_r_out = fix_r_neg ? (~fix_r + DW'(1)) : fix_r;

endmodule

// File: rtl/mdr_iter_core.sv
// Iterative multiply / restoring divide / restoring square root, one bit per cycle.
// Latency: MULT/DIV DW+3, SQRT DW/2+3, error 2 cycles from the start-sampling cycle to done.
// Backpressure: start is taken only while ready=1; otherwise dropped, nothing is queued.

module mdr_iter_core
   import mdr_pkg::*;
#(
   parameter int DW        = 10,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic          signed_mode,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [DW-1:0] result_hi,
   output logic [DW-1:0] result_lo,
   output logic [DW-1:0] remainder
);

   localparam int HW = DW / 2;
   localparam int CW = `MDR_CNT_W(DW);
   localparam logic [CW-1:0] CNT_MULDIV = CW'(DW);
   localparam logic [CW-1:0] CNT_SQRT   = CW'(HW);

   if ((DW < 4) || ((DW % 2) != 0) || (DW > MDR_MAX_DW)) begin : g_dw_check
      $error("mdr_iter_core: DW must be even, >= 4 and <= %0d", MDR_MAX_DW);
   end

   core_state_e     state;
   mdr_op_e         op_q;
   logic            sgn_q;
   logic [DW-1:0]   x_q;
   logic [DW-1:0]   y_q;
   logic [DW-1:0]   opa;      // multiplicand (MULT) or divisor (DIV) magnitude
   logic            neg_res;  // product / quotient must be negated in FIX
   logic            neg_rem;  // remainder takes the dividend's sign
   logic [2*DW-1:0] acc;      // MULT: product/multiplier; DIV: quotient; SQRT: radicand
   logic [DW-1:0]   prem;     // stored partial remainder (DIV and SQRT)
   logic [HW-1:0]   root;
   logic [CW-1:0]   cnt;

   logic [DW-1:0]   x_mag;
   logic [DW-1:0]   y_mag;
   logic            x_neg;
   logic            y_neg;
   logic [2*DW-1:0] fix_p_out;
   logic [DW-1:0]   fix_r_out;
   logic            load_err;

   mdr_sign_unit #(.DW(DW)) u_sign (
      .sgn       (sgn_q),
      .a         (x_q),
      .b         (y_q),
      .a_mag     (x_mag),
      .b_mag     (y_mag),
      .a_neg     (x_neg),
      .b_neg     (y_neg),
      .fix_p     (acc),
      .fix_p_neg (neg_res),
      .fix_r     (prem),
      .fix_r_neg (neg_rem),
      .fix_p_out (fix_p_out),
      .fix_r_out (fix_r_out)
   );

   // Conditions that end the operation straight after LOAD; the last one is
   // the only signed division whose quotient does not fit in DW bits.
   assign load_err = (op_q == OP_RSVD)
                  || ((op_q == DIV) && (y_q == '0))
                  || (sgn_q && (op_q == SQRT) && x_q[DW-1])
                  || (sgn_q && (op_q == DIV) && (x_q == {1'b1, {(DW-1){1'b0}}}) && (&y_q));

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right.
   logic [DW:0]     mul_sum;
   logic [2*DW-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*DW-1:DW]} + {1'b0, opa};
   assign mul_next = acc[0] ? {mul_sum, acc[DW-1:1]} : {1'b0, acc[2*DW-1:1]};

   // Restoring divide step on a DW+1-bit shifted partial remainder; the
   // stored remainder is always below the divisor so DW bits keep it.
   logic [DW:0] div_sh;
   logic        div_ge;
   assign div_sh = {prem, acc[DW-1]};
   assign div_ge = (div_sh >= {1'b0, opa});

   // Restoring square-root step: bring in two radicand bits and try
   // subtracting {root, 01} on a DW/2+2-bit partial remainder.
   logic [HW+1:0] sq_sh;
   logic [HW+1:0] sq_trial;
   logic          sq_ge;
   assign sq_sh    = {prem[HW-1:0], acc[DW-1:DW-2]};
   assign sq_trial = {root, 2'b01};
   assign sq_ge    = (sq_sh >= sq_trial);

   // Control FSM, iteration counter, shift datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         result_hi <= '0;
         result_lo <= '0;
         remainder <= '0;
         op_q      <= MULT;
         sgn_q     <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         opa       <= '0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         acc       <= '0;
         prem      <= '0;
         root      <= '0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= mdr_op_e'(op);
                  sgn_q <= SIGNED_EN && signed_mode;
                  x_q   <= x;
                  y_q   <= y;
                  state <= LOAD;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (load_err) begin
                  state     <= ERROR;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  error     <= 1'b1;
                  result_hi <= '0;
                  result_lo <= '0;
                  remainder <= '0;
               end else begin
                  state   <= PROCESSING;
                  neg_res <= x_neg ^ y_neg;
                  neg_rem <= x_neg;
                  prem    <= '0;
                  root    <= '0;
                  cnt     <= (op_q == SQRT) ? CNT_SQRT : CNT_MULDIV;
                  if (op_q == MULT) begin
                     opa <= x_mag;
                     acc <= {{DW{1'b0}}, y_mag};
                  end else begin
                     opa <= y_mag;
                     acc <= {{DW{1'b0}}, x_mag};
                  end
               end
            end
            PROCESSING: begin
               cnt <= cnt - CW'(1);
               case (op_q)
                  MULT: acc <= mul_next;
                  DIV: begin
                     acc  <= {acc[2*DW-1:DW], acc[DW-2:0], div_ge};
                     prem <= div_ge ? DW'(div_sh - {1'b0, opa}) : div_sh[DW-1:0];
                  end
                  SQRT: begin
                     acc  <= {acc[2*DW-1:DW], acc[DW-3:0], 2'b00};
                     root <= {root[HW-2:0], sq_ge};
                     prem <= DW'(sq_ge ? (sq_sh - sq_trial) : sq_sh);
                  end
                  default: acc <= acc;
               endcase
               if (cnt == CW'(1))
                  state <= FIX;
            end
            FIX: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               error <= 1'b0;
               case (op_q)
                  MULT: begin
                     result_hi <= fix_p_out[2*DW-1:DW];
                     result_lo <= fix_p_out[DW-1:0];
                     remainder <= '0;
                  end
                  DIV: begin
                     result_hi <= '0;
                     result_lo <= fix_p_out[DW-1:0];
                     remainder <= fix_r_out;
                  end
                  default: begin
                     result_hi <= '0;
                     result_lo <= DW'(root);
                     remainder <= prem;
                  end
               endcase
            end
            DONE, ERROR: begin
               state <= IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdr_iter_core.sv
// Directed-vector and reference-model bench for mdr_iter_core at DW=10.
// Latency: checks done latency of every operation against the expected cycle count.
// Backpressure: drives start only while ready=1, except in the deliberate ignore cases.

module tb_mdr_iter_core;

   localparam int DW = 10;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic          signed_mode;
   logic [DW-1:0] x;
   logic [DW-1:0] y;
   logic          ready;
   logic          busy;
   logic          done;
   logic          error;
   logic [DW-1:0] result_hi;
   logic [DW-1:0] result_lo;
   logic [DW-1:0] remainder;

   int n_checks = 0;
   int n_fail   = 0;

   mdr_iter_core #(.DW(DW), .SIGNED_EN(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .signed_mode (signed_mode),
      .x           (x),
      .y           (y),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .remainder   (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    op;
      logic          sm;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic          err;
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
      logic [DW-1:0] rem;
      int            lat;
      string         name;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Waits (bounded) for ready, issues one request and returns the number of
   // edges until done, counting the start-sampling edge as 1; -1 on timeout.
   task automatic run_op(input logic [1:0] o, input logic sm, input logic [DW-1:0] xa,
                         input logic [DW-1:0] ya, output int lat);
      int w;
      w = 0;
      while (!ready && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      op = o; signed_mode = sm; x = xa; y = ya; start = 1'b1;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         start = 1'b0; x = ~xa; y = ~ya; op = ~o;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic model(input logic [1:0] o, input logic sm, input logic [DW-1:0] xa,
                        input logic [DW-1:0] ya, output logic err, output logic [DW-1:0] hi,
                        output logic [DW-1:0] lo, output logic [DW-1:0] rem);
      longint xs, ys, p, q, r, rt;
      logic [63:0] pw;
      if (sm) begin
         xs = longint'($signed(xa));
         ys = longint'($signed(ya));
      end else begin
         xs = longint'({54'd0, xa});
         ys = longint'({54'd0, ya});
      end
      err = 1'b0; hi = '0; lo = '0; rem = '0;
      case (o)
         2'b00: begin
            p = xs * ys; pw = p;
            hi = pw[2*DW-1:DW]; lo = pw[DW-1:0];
         end
         2'b01: begin
            if (ys == 0 || (sm && xs == -(longint'(1) << (DW-1)) && ys == -1)) err = 1'b1;
            else begin
               q = xs / ys; r = xs % ys;
               pw = q; lo = pw[DW-1:0];
               pw = r; rem = pw[DW-1:0];
            end
         end
         2'b10: begin
            if (xs < 0) err = 1'b1;
            else begin
               rt = 0;
               while ((rt + 1) * (rt + 1) <= xs) rt++;
               pw = rt; lo = pw[DW-1:0];
               pw = xs - rt * rt; rem = pw[DW-1:0];
            end
         end
         default: err = 1'b1;
      endcase
   endtask

   initial begin
      int lat;
      int seen_done;
      logic          m_err;
      logic [DW-1:0] m_hi, m_lo, m_rem;
      logic [1:0]    r_op;
      logic          r_sm;
      logic [DW-1:0] r_x, r_y;

      //           op     sm    x        y        err   hi       lo       rem      lat name
      vecs[0]  = '{2'b00, 1'b0, 10'd25,  10'd40,  1'b0, 10'h000, 10'd1000, 10'd0,  13, "umul_25x40"};
      vecs[1]  = '{2'b00, 1'b1, 10'h3FD, 10'd7,   1'b0, 10'h3FF, 10'h3EB, 10'd0,   13, "smul_m3x7"};
      vecs[2]  = '{2'b01, 1'b0, 10'd1000,10'd7,   1'b0, 10'h000, 10'd142, 10'd6,   13, "udiv_1000_7"};
      vecs[3]  = '{2'b01, 1'b1, 10'h39C, 10'd7,   1'b0, 10'h000, 10'h3F2, 10'h3FE, 13, "sdiv_m100_7"};
      vecs[4]  = '{2'b10, 1'b0, 10'd1000,10'd0,   1'b0, 10'h000, 10'd31,  10'd39,  8,  "sqrt_1000"};
      vecs[5]  = '{2'b01, 1'b0, 10'd55,  10'd0,   1'b1, 10'h000, 10'h000, 10'h000, 2,  "div_by_zero"};
      vecs[6]  = '{2'b11, 1'b0, 10'd3,   10'd4,   1'b1, 10'h000, 10'h000, 10'h000, 2,  "op_reserved"};
      vecs[7]  = '{2'b10, 1'b1, 10'h3FC, 10'd0,   1'b1, 10'h000, 10'h000, 10'h000, 2,  "ssqrt_neg"};
      vecs[8]  = '{2'b01, 1'b1, 10'h200, 10'h3FF, 1'b1, 10'h000, 10'h000, 10'h000, 2,  "sdiv_min_m1"};
      vecs[9]  = '{2'b00, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 10'h3FE, 10'h001, 10'd0,   13, "umul_max"};
      vecs[10] = '{2'b00, 1'b1, 10'h200, 10'h200, 1'b0, 10'h100, 10'h000, 10'd0,   13, "smul_min_min"};
      vecs[11] = '{2'b01, 1'b0, 10'h200, 10'h3FF, 1'b0, 10'h000, 10'h000, 10'h200, 13, "udiv_msb_set"};
      vecs[12] = '{2'b01, 1'b1, 10'd100, 10'h3F9, 1'b0, 10'h000, 10'h3F2, 10'd2,   13, "sdiv_100_m7"};
      vecs[13] = '{2'b10, 1'b0, 10'h3FF, 10'd0,   1'b0, 10'h000, 10'd31,  10'd62,  8,  "usqrt_max"};
      vecs[14] = '{2'b10, 1'b1, 10'd0,   10'd0,   1'b0, 10'h000, 10'd0,   10'd0,   8,  "ssqrt_zero"};
      vecs[15] = '{2'b01, 1'b1, 10'h200, 10'd1,   1'b0, 10'h000, 10'h200, 10'd0,   13, "sdiv_min_1"};
      vecs[16] = '{2'b10, 1'b0, 10'd4,   10'd9,   1'b0, 10'h000, 10'd2,   10'd0,   8,  "sqrt_4"};
      vecs[17] = '{2'b00, 1'b1, 10'd0,   10'h3FB, 1'b0, 10'h000, 10'h000, 10'd0,   13, "smul_0xm5"};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; signed_mode = 1'b0; x = '0; y = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", {ready, busy, done, error}, 4'b1000);
      check("reset_results", {result_hi, result_lo, remainder}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].sm, vecs[i].x, vecs[i].y, lat);
         check($sformatf("%s latency", vecs[i].name), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("%s err/hi/lo/rem", vecs[i].name), {error, result_hi, result_lo, remainder},
               {vecs[i].err, vecs[i].hi, vecs[i].lo, vecs[i].rem});
         @(posedge clk); #1;
         check($sformatf("%s hold", vecs[i].name), {done, error, result_hi, result_lo, remainder},
               {1'b0, vecs[i].err, vecs[i].hi, vecs[i].lo, vecs[i].rem});
      end

      // Start pulsed while busy must be dropped
      op = 2'b00; signed_mode = 1'b0; x = 10'd25; y = 10'd40; start = 1'b1;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         start = (i == 3);
         if (i == 3) begin op = 2'b01; x = 10'd1; y = 10'd0; end
         if (i == 1) check("busy_after_start", {ready, busy}, 2'b01);
         if (done) begin lat = i; break; end
      end
      check("busy_ignore latency", 64'(lat), 64'd13);
      check("busy_ignore result", {error, result_hi, result_lo, remainder}, {1'b0, 10'd0, 10'd1000, 10'd0});

      // Start during the DONE cycle is ignored; held into IDLE it is accepted
      run_op(2'b01, 1'b0, 10'd1000, 10'd7, lat);
      check("b2b first result", {error, result_lo, remainder}, {1'b0, 10'd142, 10'd6});
      op = 2'b00; signed_mode = 1'b0; x = 10'd25; y = 10'd40; start = 1'b1;
      @(posedge clk); #1;
      check("start_in_done_ignored", {ready, busy, done}, 3'b100);
      run_op(2'b00, 1'b0, 10'd25, 10'd40, lat);
      check("b2b latency", 64'(lat), 64'd13);
      check("b2b result", {error, result_hi, result_lo, remainder}, {1'b0, 10'd0, 10'd1000, 10'd0});
      @(posedge clk); #1;

      // Reset in the middle of PROCESSING aborts without a done pulse
      seen_done = 0;
      op = 2'b00; signed_mode = 1'b0; x = 10'd25; y = 10'd40; start = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) seen_done++;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrun_reset flags", {ready, busy, done, error}, 4'b1000);
      check("midrun_reset results", {result_hi, result_lo, remainder}, '0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      check("midrun_reset no_done", 64'(seen_done), 64'd0);

      // Random operations against the reference model
      for (int k = 0; k < 40; k++) begin
         r_op = 2'($urandom_range(0, 3));
         r_sm = 1'($urandom_range(0, 1));
         r_x  = DW'($urandom);
         r_y  = DW'($urandom);
         model(r_op, r_sm, r_x, r_y, m_err, m_hi, m_lo, m_rem);
         run_op(r_op, r_sm, r_x, r_y, lat);
         check($sformatf("rand%0d op=%0d sm=%0d x=%0h y=%0h latency", k, r_op, r_sm, r_x, r_y),
               64'(lat), m_err ? 64'd2 : ((r_op == 2'b10) ? 64'(DW/2 + 3) : 64'(DW + 3)));
         check($sformatf("rand%0d op=%0d sm=%0d x=%0h y=%0h result", k, r_op, r_sm, r_x, r_y),
               {error, result_hi, result_lo, remainder}, {m_err, m_hi, m_lo, m_rem});
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
